vram_arbiter: RTL

Single-port video-memory arbiter between the scan-out path and the CPU. Display fetches always win; CPU writes are buffered in a small FIFO and drained into free memory slots (blanking, or gaps between fetches). CPU reads wait until all earlier buffered writes have reached memory. Sits between the VGA timing/fetch logic and the synchronous `video_mem`, and owns that memory's only address/write port.

---
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video-memory arbiter. Display fetches always win;
// CPU writes are buffered and drained into free slots, and CPU reads wait
// until every earlier buffered write has reached memory.
module vram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              wr_pending,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_PEND,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                r_wr_pending;

  logic                r_disp_rvalid;
  logic [DATA_W-1:0]   r_disp_rdata;
  logic [DATA_W-1:0]   r_cpu_rdata;

  logic                w_empty;
  logic                w_full;
  logic                w_gnt_drain;
  logic                w_gnt_cpurd;
  logic                w_push;
  logic                w_pop;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_gnt_drain = !disp_req && !w_empty;
  assign w_gnt_cpurd = !disp_req && w_empty && (r_state == S_RD_PEND);
  // Push looks only at the current count: a full FIFO refuses even on a pop.
  assign w_push      = (r_state == S_IDLE) && cpu_req && cpu_we && !w_full;
  assign w_pop       = w_gnt_drain;

  // Memory port driven straight from this cycle's fixed-priority grant.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (w_gnt_drain) begin
      mem_addr  = r_fifo_addr[r_rptr];
      mem_we    = 1'b1;
      mem_wdata = r_fifo_data[r_rptr];
    end else if (w_gnt_cpurd) begin
      mem_addr = cpu_addr;
    end
  end

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Write-buffer storage; contents need no reset, validity lives in r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= cpu_addr;
      r_fifo_data[r_wptr] <= cpu_wdata;
    end
  end

  // Write-buffer pointers, occupancy and the registered pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wr_pending <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count      <= w_count_nxt;
      r_wr_pending <= (w_count_nxt != '0);
    end
  end

  // CPU FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // CPU FSM next-state; a full FIFO leaves a write waiting in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req && cpu_we && !w_full) w_state_nxt = S_ACK;
        else if (cpu_req && !cpu_we)      w_state_nxt = S_RD_PEND;
      end
      S_RD_PEND: if (w_gnt_cpurd) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Read-data capture for both the display path and CPU reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      r_disp_rvalid <= disp_req;
      if (r_disp_rvalid)         r_disp_rdata <= mem_rdata;
      if (r_state == S_RD_WAIT)  r_cpu_rdata  <= mem_rdata;
    end
  end

  assign disp_rvalid = r_disp_rvalid;
  assign disp_rdata  = r_disp_rdata;
  assign cpu_ack     = (r_state == S_ACK);
  assign cpu_rdata   = r_cpu_rdata;
  assign wr_pending  = r_wr_pending;

endmodule
